// File: rtl/icache_pkg.sv
// Shared types and constants for the icache refill path (MSHR and memory side).
package icache_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int LINE_WORDS_DEF = 8;
  // Word index width: byte address minus the two byte-offset bits.
  localparam int WORD_IDX_W     = ADDR_W_DEF - 2;
  // Width of a word offset within a line.
  localparam int OFF_W          = $clog2(LINE_WORDS_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } refill_state_e;

  // A line-fill request: line base (word index, offset bits zero) plus the
  // critical word that is returned first.
  typedef struct packed {
    logic [WORD_IDX_W-1:0] base;
    logic [OFF_W-1:0]      start_off;
  } line_req_t;

endpackage

// File: rtl/icache_resp_mem.sv
// Backing store for the refill responder: one synchronous read port and one
// write port. A read and a write to the same word in one cycle return the old
// data (read-before-write).
module icache_resp_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Store array write port.
  // NOTE: the array has no reset; contents are undefined until written, which
  // keeps it mappable onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read data register; it drives a module output, so it is reset to zero.
  // NOTE: non-blocking assignment here and in the write block means a
  // same-cycle read of the written word sees the value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/icache_refill_responder.sv
// Memory-side responder for icache line fills. Accepts one request at a time,
// waits a fixed latency, then returns the line critical-word-first as a
// wrapping burst with ack on the last beat. Out-of-range requests get an
// ack+err pulse and no beats. The line_req_t fields are sized by icache_pkg,
// so ADDR_W and LINE_WORDS must match the package defaults.
module icache_refill_responder
  import icache_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = 32,
  parameter int LINE_WORDS  = LINE_WORDS_DEF,
  parameter int MEM_LATENCY = 4,
  parameter int MEM_WORDS   = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mshr_bus_req,
  input  logic [ADDR_W-1:0]            mshr_bus_addr,
  output logic                         bus_mshr_rvalid,
  output logic [DATA_W-1:0]            bus_mshr_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] bus_mshr_rword,
  output logic                         bus_mshr_ack,
  output logic                         bus_mshr_err,
  input  logic                         mem_wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0]            mem_wr_data
);

  localparam int MEM_AW = $clog2(MEM_WORDS);
  // Counter spans 0..MEM_LATENCY: the extra value marks the error-ack cycle.
  localparam int LAT_W  = $clog2(MEM_LATENCY + 1);

  refill_state_e   state_q, state_d;
  line_req_t       req_q, req_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic             rvalid_q, rvalid_d;
  logic [OFF_W-1:0] rword_q, rword_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic [WORD_IDX_W-1:0] in_word;
  logic [WORD_IDX_W-1:0] cur_word;
  logic [WORD_IDX_W-1:0] line_word;
  logic                  in_range;
  logic [OFF_W-1:0]      rd_idx;
  logic [OFF_W-1:0]      rd_off;
  logic                  rd_en;
  logic [MEM_AW-1:0]     rd_addr;
  logic                  unused_bits;

  assign in_word  = mshr_bus_addr[ADDR_W-1:2];
  assign cur_word = {req_q.base[WORD_IDX_W-1:OFF_W], req_q.start_off};
  assign in_range = cur_word < WORD_IDX_W'(MEM_WORDS);

  // Reads run one cycle ahead of their beat: the last WAIT cycle fetches beat
  // 0, BURST beat k fetches beat k+1. Offsets wrap within the line because
  // the sum is truncated to OFF_W bits.
  assign rd_idx    = (state_q == BURST) ? beat_q + OFF_W'(1) : '0;
  assign rd_off    = req_q.start_off + rd_idx;
  assign line_word = {req_q.base[WORD_IDX_W-1:OFF_W], rd_off};
  assign rd_addr   = line_word[MEM_AW-1:0];

  // Byte-offset bits, the always-zero base offset bits and the word index
  // bits above the store depth play no part in indexing.
  assign unused_bits = ^{mshr_bus_addr[1:0], req_q.base[OFF_W-1:0],
                         line_word[WORD_IDX_W-1:MEM_AW]};

  // Next-state, counter, read-issue and output-register logic.
  // NOTE: every signal gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    rvalid_d = 1'b0;
    rword_d  = rword_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rd_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mshr_bus_req) begin
          req_d.base      = {in_word[WORD_IDX_W-1:OFF_W], {OFF_W{1'b0}}};
          req_d.start_off = in_word[OFF_W-1:0];
          cnt_d           = '0;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAT_W'(MEM_LATENCY)) begin
          // Error ack is on the outputs this cycle; turn around next.
          state_d = DONE;
        end else if (cnt_q == LAT_W'(MEM_LATENCY - 1)) begin
          if (in_range) begin
            rd_en    = 1'b1;
            rvalid_d = 1'b1;
            rword_d  = rd_off;
            beat_d   = '0;
            state_d  = BURST;
          end else begin
            ack_d = 1'b1;
            err_d = 1'b1;
            cnt_d = cnt_q + LAT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      BURST: begin
        if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
          state_d = DONE;
        end else begin
          rd_en    = 1'b1;
          rvalid_d = 1'b1;
          rword_d  = rd_off;
          beat_d   = beat_q + OFF_W'(1);
          ack_d    = (beat_q == OFF_W'(LINE_WORDS - 2));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      rword_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      rword_q  <= rword_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  icache_resp_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_WORDS),
    .AW     (MEM_AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (bus_mshr_rdata),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data)
  );

  assign bus_mshr_rvalid = rvalid_q;
  assign bus_mshr_rword  = rword_q;
  assign bus_mshr_ack    = ack_q;
  assign bus_mshr_err    = err_q;

endmodule
